// File: rtl/loader_pkg.sv
// loader_pkg: state encoding and default parameters shared by the program loader.
package loader_pkg;
  localparam int DEF_ADDR_W    = 10;
  localparam int DEF_DATA_W    = 32;
  localparam int DEF_DEPTH     = 1024;
  localparam int DEF_WR_CYCLES = 1;
  typedef enum logic [3:0] {
    IDLE, ACCEPT, SETUP, STROBE, HOLD, FILL, RELEASE, DONE, ERROR
  } state_t;
endpackage

// File: rtl/loader_csum.sv
// loader_csum: running sum of source words compared against the checksum captured on the last beat.
module loader_csum #(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clear,
  input  logic              add,
  input  logic              cap,
  input  logic [DATA_W-1:0] data,
  input  logic [DATA_W-1:0] exp_csum,
  output logic              ok
);
  logic [DATA_W-1:0] sum, checksum;
  logic seen;
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      sum      <= '0;
      checksum <= '0;
      seen     <= 1'b0;
    end else if (clear) begin
      sum      <= '0;
      checksum <= '0;
      seen     <= 1'b0;
    end else begin
      if (add) sum <= sum + data;
      if (cap) begin
        checksum <= exp_csum;
        seen     <= 1'b1;
      end
    end
  // A load that ends at DEPTH without in_last never supplied a checksum, so it passes.
  assign ok = !seen || sum == checksum;
endmodule

// File: rtl/program_loader.sv
// program_loader: streams words into instruction memory, zero-fills to DEPTH, then releases the CPU.
// Define LOADER_CHECKSUM_EN to verify the source-word sum against in_csum before release.
module program_loader
  import loader_pkg::*;
#(
  parameter int ADDR_W    = DEF_ADDR_W,
  parameter int DATA_W    = DEF_DATA_W,
  parameter int DEPTH     = DEF_DEPTH,
  parameter int WR_CYCLES = DEF_WR_CYCLES
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_last,
  input  logic [DATA_W-1:0] in_csum,
  output logic              in_ready,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_write_n,
  output logic              override,
  output logic              cpu_reset,
  output logic              done,
  output logic              error,
  output logic [ADDR_W:0]   word_count
);
  state_t state;
  logic [3:0] cnt;
  logic last_r, filling, csum_ok, accept;
  assign accept = state == ACCEPT && in_valid;
`ifdef LOADER_CHECKSUM_EN
  loader_csum #(.DATA_W(DATA_W)) u_csum (
    .clk      (clk),
    .reset    (reset),
    .clear    (state == IDLE),
    .add      (accept),
    .cap      (accept && in_last),
    .data     (in_data),
    .exp_csum (in_csum),
    .ok       (csum_ok)
  );
`else
  logic unused_csum;
  assign unused_csum = ^in_csum;
  assign csum_ok = 1'b1;
`endif
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state       <= IDLE;
      cnt         <= '0;
      last_r      <= 1'b0;
      filling     <= 1'b0;
      in_ready    <= 1'b0;
      mem_addr    <= '0;
      mem_wdata   <= '0;
      mem_write_n <= 1'b1;
      override    <= 1'b1;
      cpu_reset   <= 1'b1;
      done        <= 1'b0;
      error       <= 1'b0;
      word_count  <= '0;
    end else begin
      case (state)
        IDLE: if (start) begin
          state    <= ACCEPT;
          mem_addr <= '0;
          in_ready <= 1'b1;
        end
        ACCEPT: if (in_valid) begin
          mem_wdata <= in_data;
          last_r    <= in_last;
          in_ready  <= 1'b0;
          state     <= SETUP;
        end
        SETUP: begin
          mem_write_n <= 1'b0;
          cnt         <= '0;
          state       <= STROBE;
        end
        STROBE: if (cnt == 4'(WR_CYCLES - 1)) begin
          mem_write_n <= 1'b1;
          state       <= HOLD;
        end else cnt <= cnt + 4'd1;
        HOLD: begin
          word_count <= word_count + {{ADDR_W{1'b0}}, !filling};
          if (mem_addr == ADDR_W'(DEPTH - 1)) begin
            if (csum_ok) begin
              state    <= RELEASE;
              override <= 1'b0;
            end else begin
              state <= ERROR;
              error <= 1'b1;
            end
          end else begin
            mem_addr <= mem_addr + ADDR_W'(1);
            if (last_r || filling) begin
              state   <= FILL;
              filling <= 1'b1;
            end else begin
              state    <= ACCEPT;
              in_ready <= 1'b1;
            end
          end
        end
        FILL: begin
          mem_wdata <= '0;
          state     <= SETUP;
        end
        RELEASE: begin
          cpu_reset <= 1'b0;
          done      <= 1'b1;
          state     <= DONE;
        end
        default: ;
      endcase
    end
endmodule

// File: tb/tb_program_loader.sv
// tb_program_loader: directed checks of load, zero-fill, strobe timing, release order and reset.
module tb_program_loader;
  localparam int AW = 4, DW = 32, DEPTH = 8, WR = 3;
  logic clk = 1'b0, reset = 1'b1, start = 1'b0, in_valid = 1'b0, in_last = 1'b0;
  logic [DW-1:0] in_data = '0, in_csum = '0;
  logic in_ready, mem_write_n, override, cpu_reset, done, error;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [AW:0] word_count;
  logic [DW-1:0] ram [DEPTH];
  logic prev_wn = 1'b1;
  logic [AW-1:0] prev_addr = '0;
  logic [DW-1:0] prev_data = '0;
  int lowlen = 0;
  int total = 0, bad = 0;

  program_loader #(.ADDR_W(AW), .DATA_W(DW), .DEPTH(DEPTH), .WR_CYCLES(WR)) dut (
    .clk(clk), .reset(reset), .start(start), .in_valid(in_valid), .in_data(in_data),
    .in_last(in_last), .in_csum(in_csum), .in_ready(in_ready), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_write_n(mem_write_n), .override(override),
    .cpu_reset(cpu_reset), .done(done), .error(error), .word_count(word_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Instruction memory model: written on any clock edge with the strobe low.
  always @(posedge clk)
    if (mem_write_n === 1'b0 && override === 1'b1) ram[mem_addr[2:0]] = mem_wdata;

  // Strobe monitor: pulse width and address/data stability around each pulse.
  always @(negedge clk) begin
    if (reset) prev_wn = 1'b1;
    else begin
      if (mem_write_n === 1'b0) begin
        lowlen = prev_wn ? 1 : lowlen + 1;
        chk("strobe_addr_stable", mem_addr, prev_addr);
        chk("strobe_data_stable", mem_wdata, prev_data);
      end else if (!prev_wn) begin
        chk("strobe_width", lowlen, WR);
        chk("hold_addr_stable", mem_addr, prev_addr);
        chk("hold_data_stable", mem_wdata, prev_data);
      end
      prev_wn = mem_write_n;
      prev_addr = mem_addr;
      prev_data = mem_wdata;
    end
  end

  task automatic do_reset();
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic clear_ram();
    for (int i = 0; i < DEPTH; i++) ram[i] = 32'hDEAD_BEEF;
  endtask

  task automatic start_pulse();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic send_word(input logic [DW-1:0] d, input logic l, input logic [DW-1:0] cs);
    int c = 0;
    while (in_ready !== 1'b1 && c < 100) begin
      @(negedge clk);
      c++;
    end
    chk("ready_timeout", c < 100, 1);
    in_valid = 1'b1;
    in_data = d;
    in_last = l;
    in_csum = cs;
    @(negedge clk);
    in_valid = 1'b0;
    in_last = 1'b0;
  endtask

  task automatic wait_release();
    int c = 0;
    while (override !== 1'b0 && c < 400) begin
      @(negedge clk);
      c++;
    end
    chk("release_timeout", c < 400, 1);
    chk("release_cpu_reset", cpu_reset, 1);
    chk("release_done", done, 0);
    @(negedge clk);
    chk("done_cpu_reset", cpu_reset, 0);
    chk("done_flag", done, 1);
    chk("done_error", error, 0);
  endtask

  initial begin
    int n, lastc, c;
    logic extra;
    clear_ram();
    do_reset();
    chk("rst_override", override, 1);
    chk("rst_cpu_reset", cpu_reset, 1);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_write_n", mem_write_n, 1);
    chk("rst_done", done, 0);
    chk("rst_error", error, 0);
    chk("rst_word_count", word_count, 0);
    chk("rst_addr", mem_addr, 0);
    chk("rst_wdata", mem_wdata, 0);

    // Three words then zero-fill.
    start_pulse();
    chk("accept_ready", in_ready, 1);
    send_word(32'h11, 1'b0, 32'h0);
    send_word(32'h12, 1'b0, 32'h0);
    send_word(32'h13, 1'b1, 32'h36);
    wait_release();
    chk("t1_ram0", ram[0], 32'h11);
    chk("t1_ram1", ram[1], 32'h12);
    chk("t1_ram2", ram[2], 32'h13);
    for (int i = 3; i < DEPTH; i++) chk("t1_fill", ram[i], 32'h0);
    chk("t1_word_count", word_count, 3);
    start_pulse();
    repeat (3) @(negedge clk);
    chk("done_start_ignored_done", done, 1);
    chk("done_start_ignored_override", override, 0);
    chk("done_start_ignored_ready", in_ready, 0);
    chk("done_start_ignored_wn", mem_write_n, 1);

    // Full DEPTH with in_valid held high and no in_last.
    clear_ram();
    do_reset();
    start_pulse();
    in_valid = 1'b1;
    n = 0;
    lastc = 0;
    extra = 1'b0;
    for (c = 0; c < 400 && done !== 1'b1; c++) begin
      in_data = 32'h101 + n;
      if (in_ready === 1'b1) begin
        if (n >= DEPTH) extra = 1'b1;
        if (n > 0) chk("accept_gap", c - lastc, 1 + 1 + WR + 1);
        lastc = c;
        n++;
      end
      @(negedge clk);
    end
    in_valid = 1'b0;
    chk("t2_timeout", c < 400, 1);
    chk("t2_accepted", n, DEPTH);
    chk("t2_no_extra_ready", extra, 0);
    chk("t2_ram0", ram[0], 32'h101);
    chk("t2_ram3", ram[3], 32'h104);
    chk("t2_ram7", ram[7], 32'h108);
    chk("t2_word_count", word_count, DEPTH);
    chk("t2_cpu_reset", cpu_reset, 0);

    // Reset in the middle of word 2's strobe, then reload from address 0.
    do_reset();
    start_pulse();
    send_word(32'hA0, 1'b0, 32'h0);
    send_word(32'hA1, 1'b0, 32'h0);
    send_word(32'hA2, 1'b0, 32'h0);
    c = 0;
    while (!(mem_write_n === 1'b0 && mem_addr === AW'(2)) && c < 100) begin
      @(negedge clk);
      c++;
    end
    chk("t3_strobe_timeout", c < 100, 1);
    #2 reset = 1'b1;
    #1;
    chk("t3_async_write_n", mem_write_n, 1);
    chk("t3_async_override", override, 1);
    chk("t3_async_cpu_reset", cpu_reset, 1);
    chk("t3_async_addr", mem_addr, 0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    clear_ram();
    start_pulse();
    send_word(32'hB0, 1'b1, 32'hB0);
    wait_release();
    chk("t3_ram0", ram[0], 32'hB0);
    for (int i = 1; i < DEPTH; i++) chk("t3_fill", ram[i], 32'h0);
    chk("t3_word_count", word_count, 1);

    // Checksum mismatch (only enforced with LOADER_CHECKSUM_EN).
    do_reset();
    start_pulse();
    send_word(32'd1, 1'b0, 32'd0);
    send_word(32'd2, 1'b0, 32'd0);
    send_word(32'd3, 1'b1, 32'd7);
`ifdef LOADER_CHECKSUM_EN
    c = 0;
    while (error !== 1'b1 && c < 400) begin
      @(negedge clk);
      c++;
    end
    chk("t4_error_timeout", c < 400, 1);
    repeat (3) @(negedge clk);
    chk("t4_error", error, 1);
    chk("t4_cpu_reset", cpu_reset, 1);
    chk("t4_override", override, 1);
    chk("t4_done", done, 0);
`else
    wait_release();
    chk("t4_error_off", error, 0);
`endif
    do_reset();
    start_pulse();
    send_word(32'd1, 1'b0, 32'd0);
    send_word(32'd2, 1'b0, 32'd0);
    send_word(32'd3, 1'b1, 32'd6);
    wait_release();
    chk("t5_word_count", word_count, 3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/program_loader.md
PROGRAM_LOADER -- requirements
Module: program_loader

Interface
REQ-001 Parameter: ADDR_W, default 10, memory word-address width.
REQ-002 Parameter: DATA_W, default 32, memory word width.
REQ-003 Parameter: DEPTH, default 1024, number of memory words to initialise; SHALL satisfy DEPTH <= 2**ADDR_W.
REQ-004 Parameter: WR_CYCLES, default 1, cycles mem_write_n is held low per word; SHALL be 1..15.
REQ-005 Port: clk  input  1  the single clock; all state changes on its rising edge.
REQ-006 Port: reset  input  1  asynchronous, active-high reset.
REQ-007 Port: start  input  1  single-cycle request to begin loading.
REQ-008 Port: in_valid  input  1  source word valid.
REQ-009 Port: in_data  input  DATA_W  source word.
REQ-010 Port: in_last  input  1  marks final source word; qualified by in_valid.
REQ-011 Port: in_csum  input  DATA_W  expected checksum, sampled with the in_last beat.
REQ-012 Port: in_ready  output  1  loader accepts a word this cycle.
REQ-013 Port: mem_addr  output  ADDR_W  memory word address.
REQ-014 Port: mem_wdata  output  DATA_W  memory write data.
REQ-015 Port: mem_write_n  output  1  active-low memory write strobe.
REQ-016 Port: override  output  1  memory-port mux select; 1 = loader owns the instruction memory.
REQ-017 Port: cpu_reset  output  1  reset to the CPU; 1 = held in reset.
REQ-018 Port: done  output  1  load complete, CPU released.
REQ-019 Port: error  output  1  checksum mismatch, sticky.
REQ-020 Port: word_count  output  ADDR_W+1  number of source words written.

Function
REQ-021 FSM states: IDLE, ACCEPT, SETUP, STROBE, HOLD, FILL, RELEASE, DONE, ERROR.
REQ-022 IDLE: override=1, cpu_reset=1, in_ready=0; start=1 -> ACCEPT with mem_addr=0.
REQ-023 ACCEPT: in_ready=1; in_valid=1 captures in_data into mem_wdata and records in_last, then -> SETUP; otherwise stay.
REQ-024 SETUP: one cycle, mem_write_n=1, address and data stable; -> STROBE.
REQ-025 STROBE: mem_write_n=0 for exactly WR_CYCLES cycles, then -> HOLD.
REQ-026 HOLD: one cycle, mem_write_n=1, data/address unchanged; word_count increments for source words only.
REQ-027 After HOLD: if mem_addr==DEPTH-1 -> RELEASE; else mem_addr increments and next state is FILL if last recorded or already filling, else ACCEPT.
REQ-028 FILL: mem_wdata=0, in_ready=0, -> SETUP; zero-fills every remaining address up to DEPTH-1.
REQ-029 DEPTH words written without in_last: load ends normally; further input is never accepted (in_ready=0).
REQ-030 in_last on the first word: word 0 written, addresses 1..DEPTH-1 zero-filled.
REQ-031 RELEASE: override=0, cpu_reset=1 for one cycle; -> DONE.
REQ-032 DONE: override=0, cpu_reset=0, done=1; start ignored; exit only by reset.
REQ-033 start while not in IDLE SHALL be ignored.
REQ-034 Per word cost: 1 accept cycle (minimum) + 1 + WR_CYCLES + 1 cycles.

Reset
REQ-035 reset=1 asynchronously forces IDLE, mem_addr=0, mem_wdata=0, mem_write_n=1, override=1, cpu_reset=1, in_ready=0, done=0, error=0, word_count=0, checksum=0.
REQ-036 Reset mid-strobe SHALL deassert mem_write_n immediately; partially written word is not guaranteed.

Configuration
REQ-037 Macro LOADER_CHECKSUM_EN defined: running sum modulo 2**DATA_W of source words (fill words excluded) is compared with in_csum captured on the in_last beat, before RELEASE; mismatch -> ERROR (override=1, cpu_reset=1, error=1) until reset.
REQ-038 Without LOADER_CHECKSUM_EN: in_csum ignored, error tied 0, ERROR state unreachable; port list unchanged.

Structure
REQ-039 Package loader_pkg holds the state enumeration and the default parameter constants.
REQ-040 Sub-module loader_csum (accumulator + compare) is instantiated only under LOADER_CHECKSUM_EN.

Verification
REQ-041 DEPTH=8, WR_CYCLES=1; words 0x11..0x13, in_last on 0x13 -> RAM[0..2]=0x11,0x12,0x13, RAM[3..7]=0, word_count=3, done=1.
REQ-042 in_valid held high, 8 words, no in_last, DEPTH=8 -> in_ready never asserted after the 8th word; RAM[7]=8th word.
REQ-043 WR_CYCLES=3 -> every mem_write_n low pulse is exactly 3 cycles with mem_addr/mem_wdata stable one cycle before and after.
REQ-044 Completion ordering -> override falls exactly one cycle before cpu_reset falls.
REQ-045 reset asserted during STROBE of word 2 -> mem_write_n=1, override=1, cpu_reset=1 same cycle; restart reloads from address 0.
REQ-046 LOADER_CHECKSUM_EN, words 1,2,3 with in_csum=7 -> error=1, cpu_reset stays 1; with in_csum=6 -> done=1.
